tlb_op_ctrl: RTL
================

Name: tlb_op_ctrl

Overview:
Sequencer for the TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. It sits between the EX/MEM pipeline and the 16-entry TLB. It owns the TLB write, read and invtlb ports. It time-shares TLB search port 1 with load/store translation and keeps a round-robin fill pointer for TLBFILL.

Parameters:
TLBNUM, 16, number of TLB entries; a power of 2.
IDXW, $clog2(TLBNUM), width of the entry index.
ENT_W, 89, packed entry width. Fields from MSB to LSB: e, vppn[18:0], ps[5:0], asid[9:0], g, ppn0[19:0], plv0[1:0], mat0[1:0], d0, v0, ppn1[19:0], plv1[1:0], mat1[1:0], d1, v1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  operation request
req_ready  out  1  controller idle; can accept a request
req_op  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV, 5..7 illegal
req_index  in  IDXW  index for RD and WR
req_inv_op  in  5  INVTLB op code
req_asid  in  10  ASID for SRCH and INV
req_vppn  in  19  VPPN for SRCH and INV
req_entry  in  ENT_W  entry data for WR and FILL
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  illegal req_op, or req_inv_op>6
rsp_found  out  1  SRCH hit
rsp_index  out  IDXW  SRCH hit index, or index written by WR/FILL
rsp_entry  out  ENT_W  entry captured by RD
mem_s1_vppn  in  19  load/store search VPPN
mem_s1_va_bit12  in  1  load/store VA bit 12
mem_s1_asid  in  10  load/store ASID
mem_s1_grant  out  1  search port 1 currently serves load/store
tlb_s1_vppn  out  19  to TLB search port 1
tlb_s1_va_bit12  out  1  to TLB search port 1
tlb_s1_asid  out  10  to TLB search port 1
tlb_s1_found  in  1  from TLB search port 1
tlb_s1_index  in  IDXW  from TLB search port 1
tlb_we  out  1  TLB write enable
tlb_w_index  out  IDXW  TLB write index
tlb_w_entry  out  ENT_W  TLB write data
tlb_r_index  out  IDXW  TLB read index
tlb_r_entry  in  ENT_W  TLB read data (combinational in r_index)
tlb_invtlb_valid  out  1  invtlb strobe
tlb_invtlb_op  out  5  invtlb op code

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- req_ready = (state==IDLE).
- Accept on req_valid & req_ready:
  - Latch op, index, inv_op, asid, vppn and entry into internal registers.
  - Legal op: go to EXEC.
  - Illegal op: go straight to RESP with the error flag set. No TLB side effect.
- EXEC lasts exactly 1 cycle and drives the TLB from the latched registers:
  - SRCH: drive the latched vppn/asid on port 1, va_bit12=0. Capture tlb_s1_found and tlb_s1_index at the end of the cycle.
  - RD: tlb_r_index = latched index. Capture tlb_r_entry at the end of the cycle.
  - WR: tlb_we=1, tlb_w_index = latched index, tlb_w_entry = latched entry.
  - FILL: tlb_we=1, tlb_w_index = fill_ptr, tlb_w_entry = latched entry. fill_ptr increments, wrapping TLBNUM-1 -> 0.
  - INV: tlb_invtlb_valid=1, tlb_invtlb_op = latched inv_op, latched vppn/asid driven on port 1. The strobe is asserted for inv_op>6 too (the TLB treats these as a no-op); rsp_err=1 in that case.
- RESP lasts 1 cycle:
  - rsp_valid=1; return to IDLE.
  - Latency from the accept cycle T: rsp_valid at T+2. Back-to-back throughput is 1 operation per 3 cycles.
  - No response backpressure.
- rsp_found, rsp_index, rsp_entry and rsp_err:
  - Valid only while rsp_valid=1, and hold their value until the next RESP.
  - rsp_index for SRCH: the hit index if found, else 0.
  - rsp_index for WR/FILL: the written index.
  - For ops that do not produce a field, that field is 0.
- Port-1 arbitration:
  - In EXEC with op SRCH or INV: mem_s1_grant=0 and the tlb_s1_* outputs carry controller values.
  - Otherwise: mem_s1_grant=1 and tlb_s1_* = mem_s1_* (combinational pass-through).
  - The pipeline stalls any load/store whose translation overlaps a cycle with grant=0.
- tlb_we and tlb_invtlb_valid are never both 1. Both are 0 outside EXEC.
- tlb_r_index = latched index at all times.
- Reset (async, immediate):
  - state=IDLE, fill_ptr=0, all latched registers 0.
  - Outputs: rsp_*=0, tlb_we=0, tlb_invtlb_valid=0, mem_s1_grant=1, req_ready=1.
  - Reset asserted during EXEC aborts the operation. No write or invalidation occurs after the reset edge.
- fill_ptr changes only on FILL.

Test Plan:
- Reset mid-EXEC of a WR: assert reset while tlb_we=1 -> tlb_we=0 immediately; after release, req_ready=1, fill_ptr=0, and rsp_valid is never seen for the aborted operation.
- WR index 5 at cycle T, then RD index 5 -> at T+1 tlb_we=1 and tlb_w_index=5; the RD returns the same entry in rsp_entry at accept+2.
- SRCH vppn=0x12345, asid=3 after WR of a matching entry at index 7 -> rsp_found=1, rsp_index=7. During EXEC mem_s1_grant=0 and tlb_s1_vppn=0x12345; otherwise it tracks mem_s1_vppn.
- 17 consecutive FILLs -> written indices 0,1,...,15,0; rsp_index follows that sequence; each rsp_valid comes 2 cycles after its accept.
- INV inv_op=5, asid=3, vppn=0x12345 -> tlb_invtlb_valid=1 for exactly 1 cycle with op=5 and rsp_err=0. inv_op=9 -> strobe asserted, rsp_err=1.
- Illegal req_op=6 -> rsp_valid=1 and rsp_err=1 at accept+1; tlb_we and tlb_invtlb_valid stay 0.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// Sequencer for the TLB maintenance instructions (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB).
// Owns the TLB write/read/invtlb ports and borrows search port 1 from load/store for one cycle.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM),
  parameter int ENT_W  = 89
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [IDXW-1:0]  req_index,
  input  logic [4:0]       req_inv_op,
  input  logic [9:0]       req_asid,
  input  logic [18:0]      req_vppn,
  input  logic [ENT_W-1:0] req_entry,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic             rsp_found,
  output logic [IDXW-1:0]  rsp_index,
  output logic [ENT_W-1:0] rsp_entry,
  input  logic [18:0]      mem_s1_vppn,
  input  logic             mem_s1_va_bit12,
  input  logic [9:0]       mem_s1_asid,
  output logic             mem_s1_grant,
  output logic [18:0]      tlb_s1_vppn,
  output logic             tlb_s1_va_bit12,
  output logic [9:0]       tlb_s1_asid,
  input  logic             tlb_s1_found,
  input  logic [IDXW-1:0]  tlb_s1_index,
  output logic             tlb_we,
  output logic [IDXW-1:0]  tlb_w_index,
  output logic [ENT_W-1:0] tlb_w_entry,
  output logic [IDXW-1:0]  tlb_r_index,
  input  logic [ENT_W-1:0] tlb_r_entry,
  output logic             tlb_invtlb_valid,
  output logic [4:0]       tlb_invtlb_op
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [IDXW-1:0]  r_index;
  logic [4:0]       r_inv_op;
  logic [9:0]       r_asid;
  logic [18:0]      r_vppn;
  logic [ENT_W-1:0] r_entry;
  logic [IDXW-1:0]  r_fill_ptr;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic             r_rsp_found;
  logic [IDXW-1:0]  r_rsp_index;
  logic [ENT_W-1:0] r_rsp_entry;

  logic w_exec;
  logic w_s1_ctrl;

  // Response fields are rebuilt on every entry into RESP and held until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_index     <= '0;
      r_inv_op    <= '0;
      r_asid      <= '0;
      r_vppn      <= '0;
      r_entry     <= '0;
      r_fill_ptr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_found <= 1'b0;
      r_rsp_index <= '0;
      r_rsp_entry <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (req_valid) begin
            r_op     <= req_op;
            r_index  <= req_index;
            r_inv_op <= req_inv_op;
            r_asid   <= req_asid;
            r_vppn   <= req_vppn;
            r_entry  <= req_entry;
            if (req_op > OP_INV) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_found <= 1'b0;
              r_rsp_index <= '0;
              r_rsp_entry <= '0;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_found <= 1'b0;
          r_rsp_index <= '0;
          r_rsp_entry <= '0;
          case (r_op)
            OP_SRCH: begin
              r_rsp_found <= tlb_s1_found;
              r_rsp_index <= tlb_s1_found ? tlb_s1_index : '0;
            end
            OP_RD:   r_rsp_entry <= tlb_r_entry;
            OP_WR:   r_rsp_index <= r_index;
            OP_FILL: begin
              r_rsp_index <= r_fill_ptr;
              r_fill_ptr  <= r_fill_ptr + IDXW'(1);
            end
            OP_INV:  r_rsp_err <= (r_inv_op > 5'd6);
            default: r_rsp_err <= 1'b1;
          endcase
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Port 1 is borrowed only for the single EXEC cycle of SRCH/INV; otherwise load/store owns it.
  assign w_exec    = (r_state == S_EXEC);
  assign w_s1_ctrl = w_exec && ((r_op == OP_SRCH) || (r_op == OP_INV));

  assign req_ready        = (r_state == S_IDLE);
  assign rsp_valid        = r_rsp_valid;
  assign rsp_err          = r_rsp_err;
  assign rsp_found        = r_rsp_found;
  assign rsp_index        = r_rsp_index;
  assign rsp_entry        = r_rsp_entry;

  assign mem_s1_grant     = !w_s1_ctrl;
  assign tlb_s1_vppn      = w_s1_ctrl ? r_vppn : mem_s1_vppn;
  assign tlb_s1_va_bit12  = w_s1_ctrl ? 1'b0   : mem_s1_va_bit12;
  assign tlb_s1_asid      = w_s1_ctrl ? r_asid : mem_s1_asid;

  assign tlb_we           = w_exec && ((r_op == OP_WR) || (r_op == OP_FILL));
  assign tlb_w_index      = (r_op == OP_FILL) ? r_fill_ptr : r_index;
  assign tlb_w_entry      = r_entry;
  assign tlb_r_index      = r_index;
  assign tlb_invtlb_valid = w_exec && (r_op == OP_INV);
  assign tlb_invtlb_op    = r_inv_op;

endmodule
